// File: rtl/counter_run_controller_if.sv
// counter_run_controller_if: control and status bundle between board inputs and the run controller
// Ports: master drives start/stop/hold/mode_auto/up_down/load_value/terminal_value/prescale
//        and observes count/busy/done/wrap/state; slave is the controller side.
interface counter_run_controller_if #(
    parameter int WIDTH      = 3,
    parameter int PRESCALE_W = 4
);
    logic                  start;
    logic                  stop;
    logic                  hold;
    logic                  mode_auto;
    logic                  up_down;
    logic [WIDTH-1:0]      load_value;
    logic [WIDTH-1:0]      terminal_value;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  done;
    logic                  wrap;
    logic [1:0]            state;
    modport master (
        output start, stop, hold, mode_auto, up_down, load_value, terminal_value, prescale,
        input  count, busy, done, wrap, state
    );
    modport slave (
        input  start, stop, hold, mode_auto, up_down, load_value, terminal_value, prescale,
        output count, busy, done, wrap, state
    );
endinterface

// File: rtl/counter_run_controller.sv
// counter_run_controller: FSM-sequenced up/down counter with prescaled ticks, hold, one-shot/auto-reload
// Ports: input_clock1_1 clock, input_reset1_2 async active-high reset, bus slave modport
//        carrying run controls in and count/busy/done/wrap/state out.
module counter_run_controller #(
    parameter int WIDTH      = 3,
    parameter int PRESCALE_W = 4
) (
    input  logic                    input_clock1_1,
    input  logic                    input_reset1_2,
    counter_run_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10, DONE = 2'b11} state_t;
    state_t                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d, load_q, load_d, term_q, term_d;
    logic [PRESCALE_W-1:0] psc_q, psc_d, ps_q, ps_d;
    logic                  auto_q, auto_d, up_q, up_d;
    logic                  done_q, done_d, wrap_q, wrap_d, busy_q, busy_d;
    logic                  tick;
    assign tick = psc_q == ps_q;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        psc_d   = psc_q;
        load_d  = load_q;
        term_d  = term_q;
        ps_d    = ps_q;
        auto_d  = auto_q;
        up_d    = up_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        if (bus.stop) begin
            state_d = IDLE;
            psc_d   = '0;
        end else if ((state_q == IDLE || state_q == DONE) && bus.start) begin
            state_d = RUN;
            count_d = bus.load_value;
            psc_d   = '0;
            load_d  = bus.load_value;
            term_d  = bus.terminal_value;
            ps_d    = bus.prescale;
            auto_d  = bus.mode_auto;
            up_d    = bus.up_down;
        end else if (state_q == RUN) begin
            if (bus.hold) begin
                state_d = HOLD;
            end else if (tick) begin
                psc_d = '0;
                if (count_q == term_q) begin
                    done_d  = 1'b1;
                    wrap_d  = auto_q;
                    count_d = auto_q ? load_q : count_q;
                    state_d = auto_q ? RUN : DONE;
                end else begin
                    count_d = up_q ? count_q + 1'b1 : count_q - 1'b1;
                end
            end else begin
                psc_d = psc_q + 1'b1;
            end
        end else if (state_q == HOLD && !bus.hold) begin
            // the release cycle is still a HOLD cycle, so the prescaler stays frozen
            state_d = RUN;
        end
        busy_d = state_d == RUN || state_d == HOLD;
    end
    always_ff @(posedge input_clock1_1 or posedge input_reset1_2) begin
        if (input_reset1_2) begin
            state_q <= IDLE;
            count_q <= '0;
            psc_q   <= '0;
            load_q  <= '0;
            term_q  <= '0;
            ps_q    <= '0;
            auto_q  <= 1'b0;
            up_q    <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            psc_q   <= psc_d;
            load_q  <= load_d;
            term_q  <= term_d;
            ps_q    <= ps_d;
            auto_q  <= auto_d;
            up_q    <= up_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
        end
    end
    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.wrap  = wrap_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_counter_run_controller.sv
// tb_counter_run_controller: directed self-checking bench for counter_run_controller
module tb_counter_run_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    counter_run_controller_if #(.WIDTH(3), .PRESCALE_W(4)) bus ();
    counter_run_controller #(.WIDTH(3), .PRESCALE_W(4)) dut (
        .input_clock1_1(clk),
        .input_reset1_2(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic st(input string tag, input logic [2:0] c, input logic [1:0] s,
                      input logic b, input logic d, input logic w);
        chk({tag, ".count"}, {5'd0, bus.count}, {5'd0, c});
        chk({tag, ".state"}, {6'd0, bus.state}, {6'd0, s});
        chk({tag, ".busy"}, {7'd0, bus.busy}, {7'd0, b});
        chk({tag, ".done"}, {7'd0, bus.done}, {7'd0, d});
        chk({tag, ".wrap"}, {7'd0, bus.wrap}, {7'd0, w});
    endtask
    task automatic go(input logic a, input logic u, input logic [2:0] l,
                      input logic [2:0] t, input logic [3:0] p);
        bus.mode_auto = a;
        bus.up_down = u;
        bus.load_value = l;
        bus.terminal_value = t;
        bus.prescale = p;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask
    initial begin
        bus.start = 0; bus.stop = 0; bus.hold = 0; bus.mode_auto = 0; bus.up_down = 0;
        bus.load_value = 0; bus.terminal_value = 0; bus.prescale = 0;
        #12;
        st("reset", 3'd0, 2'b00, 0, 0, 0);
        rst = 1'b0;
        cyc();
        st("idle", 3'd0, 2'b00, 0, 0, 0);
        // one-shot up 0..3
        go(0, 1, 3'd0, 3'd3, 4'd0);
        st("os0", 3'd0, 2'b01, 1, 0, 0);
        cyc(); st("os1", 3'd1, 2'b01, 1, 0, 0);
        cyc(); st("os2", 3'd2, 2'b01, 1, 0, 0);
        cyc(); st("os3", 3'd3, 2'b01, 1, 0, 0);
        cyc(); st("os_done", 3'd3, 2'b11, 0, 1, 0);
        cyc(); st("os_after", 3'd3, 2'b11, 0, 0, 0);
        // auto-reload down 1,0,7,6 -> 1
        go(1, 0, 3'd1, 3'd6, 4'd0);
        st("au0", 3'd1, 2'b01, 1, 0, 0);
        cyc(); st("au1", 3'd0, 2'b01, 1, 0, 0);
        cyc(); st("au2", 3'd7, 2'b01, 1, 0, 0);
        cyc(); st("au3", 3'd6, 2'b01, 1, 0, 0);
        cyc(); st("au_wrap", 3'd1, 2'b01, 1, 1, 1);
        cyc(); st("au5", 3'd0, 2'b01, 1, 0, 0);
        cyc(); cyc(); st("au_term", 3'd6, 2'b01, 1, 0, 0);
        // stop+hold at a would-be terminal tick: IDLE, count kept, no pulses
        bus.stop = 1; bus.hold = 1;
        cyc(); st("stop_hold", 3'd6, 2'b00, 0, 0, 0);
        bus.hold = 0;
        // start+stop in IDLE stays IDLE
        bus.start = 1;
        cyc(); st("start_stop", 3'd6, 2'b00, 0, 0, 0);
        bus.start = 0; bus.stop = 0;
        cyc(); st("idle2", 3'd6, 2'b00, 0, 0, 0);
        // prescale 2 with a 4-cycle hold mid-period
        go(0, 1, 3'd2, 3'd7, 4'd2);
        st("ps_n0", 3'd2, 2'b01, 1, 0, 0);
        cyc(); st("ps_n1", 3'd2, 2'b01, 1, 0, 0);
        cyc(); st("ps_n2", 3'd2, 2'b01, 1, 0, 0);
        cyc(); st("ps_n3", 3'd3, 2'b01, 1, 0, 0);
        cyc(); st("ps_n4", 3'd3, 2'b01, 1, 0, 0);
        bus.hold = 1;
        // start is ignored while running or holding
        bus.load_value = 3'd0;
        cyc(); st("hold1", 3'd3, 2'b10, 1, 0, 0);
        bus.start = 1;
        cyc(); st("hold2", 3'd3, 2'b10, 1, 0, 0);
        bus.start = 0;
        cyc(); st("hold3", 3'd3, 2'b10, 1, 0, 0);
        cyc(); st("hold4", 3'd3, 2'b10, 1, 0, 0);
        bus.hold = 0;
        cyc(); st("resume", 3'd3, 2'b01, 1, 0, 0);
        cyc(); st("ps_r1", 3'd3, 2'b01, 1, 0, 0);
        cyc(); st("ps_r2", 3'd4, 2'b01, 1, 0, 0);
        cyc(); cyc(); cyc(); st("ps_r5", 3'd5, 2'b01, 1, 0, 0);
        // asynchronous reset mid-run with count=5
        #2 rst = 1'b1;
        #1 st("async_rst", 3'd0, 2'b00, 0, 0, 0);
        #1 rst = 1'b0;
        cyc(); st("post_rst", 3'd0, 2'b00, 0, 0, 0);
        // load == terminal fires on the first tick
        go(0, 1, 3'd5, 3'd5, 4'd0);
        st("eq0", 3'd5, 2'b01, 1, 0, 0);
        cyc(); st("eq_done", 3'd5, 2'b11, 0, 1, 0);
        // mid-run input changes are ignored until the next start
        go(0, 1, 3'd1, 3'd2, 4'd0);
        st("sh0", 3'd1, 2'b01, 1, 0, 0);
        bus.load_value = 3'd6; bus.terminal_value = 3'd7; bus.up_down = 0; bus.prescale = 4'd3;
        cyc(); st("sh1", 3'd2, 2'b01, 1, 0, 0);
        cyc(); st("sh_done", 3'd2, 2'b11, 0, 1, 0);
        bus.up_down = 1; bus.prescale = 4'd0;
        go(0, 1, 3'd6, 3'd7, 4'd0);
        st("new0", 3'd6, 2'b01, 1, 0, 0);
        cyc(); st("new1", 3'd7, 2'b01, 1, 0, 0);
        cyc(); st("new_done", 3'd7, 2'b11, 0, 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
